// File: rtl/puf_response_collector.sv
// puf_response_collector
// Drives a ring-oscillator PUF with an LFSR-generated challenge sequence,
// captures one response per ready pulse, concatenates the responses into a
// key (first response in the MSBs) and accumulates their total Hamming weight.
// A per-wait timeout aborts the run if the PUF stops answering.
module puf_response_collector #(
    parameter int N_CHALL = 4,
    parameter int HW_W    = 6,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             seed,
    input  logic                   puf_ready,
    input  logic [7:0]             puf_response,
    output logic                   puf_en,
    output logic [7:0]             puf_chall,
    output logic                   busy,
    output logic [8*N_CHALL-1:0]   key,
    output logic                   key_valid,
    output logic [HW_W-1:0]        hw_total,
    output logic                   timeout_err
);

    localparam int KW   = 8 * N_CHALL;
    localparam int RC_W = $clog2(N_CHALL + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_WAIT_LOW = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    // Number of set bits in one 8-bit response.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'd0, v[i]};
        end
        return s;
    endfunction

    state_t            r_state;
    logic [7:0]        r_chall;
    logic [RC_W-1:0]   r_round;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_puf_en;
    logic [7:0]        r_puf_chall;
    logic              r_busy;
    logic [KW-1:0]     r_key;
    logic              r_key_valid;
    logic [HW_W-1:0]   r_hw_total;
    logic              r_timeout_err;

    logic [KW-1:0]     w_key_next;
    logic [7:0]        w_chall_next;
    logic [3:0]        w_resp_weight;
    logic              w_to_expired;
    logic              w_last_round;

    // Next-value datapath: key shift-in, LFSR step, response weight, timeout and last-round flags.
    always_comb begin
        w_key_next      = r_key << 8;
        w_key_next[7:0] = puf_response;
        w_chall_next    = {r_chall[6:0], r_chall[7] ^ r_chall[5] ^ r_chall[4] ^ r_chall[3]};
        w_resp_weight   = popcount8(puf_response);
        w_to_expired    = (r_to_cnt == TO_W'(TIMEOUT - 1));
        w_last_round    = (r_round == RC_W'(N_CHALL));
    end

    // Run-control FSM with all outputs registered; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_chall       <= 8'h00;
            r_round       <= '0;
            r_to_cnt      <= '0;
            r_puf_en      <= 1'b0;
            r_puf_chall   <= 8'h00;
            r_busy        <= 1'b0;
            r_key         <= '0;
            r_key_valid   <= 1'b0;
            r_hw_total    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_key         <= '0;
                        r_hw_total    <= '0;
                        r_key_valid   <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_round       <= '0;
                        r_chall       <= (seed == 8'h00) ? 8'h01 : seed;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_ISSUE: begin
                    r_puf_chall <= r_chall;
                    r_puf_en    <= 1'b1;
                    r_to_cnt    <= '0;
                    r_state     <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (puf_ready) begin
                        r_key      <= w_key_next;
                        r_hw_total <= r_hw_total + HW_W'(w_resp_weight);
                        r_round    <= r_round + RC_W'(1);
                        r_to_cnt   <= '0;
                        r_state    <= S_WAIT_LOW;
                    end else if (w_to_expired) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_puf_en      <= 1'b0;
                        r_key_valid   <= 1'b0;
                        r_to_cnt      <= '0;
                        r_state       <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_WAIT_LOW: begin
                    if (!puf_ready) begin
                        r_to_cnt <= '0;
                        if (w_last_round) begin
                            r_key_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_puf_en    <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_chall <= w_chall_next;
                            r_state <= S_ISSUE;
                        end
                    end else if (w_to_expired) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_puf_en      <= 1'b0;
                        r_key_valid   <= 1'b0;
                        r_to_cnt      <= '0;
                        r_state       <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign puf_en      = r_puf_en;
    assign puf_chall   = r_puf_chall;
    assign busy        = r_busy;
    assign key         = r_key;
    assign key_valid   = r_key_valid;
    assign hw_total    = r_hw_total;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_puf_response_collector.sv
// Self-checking bench for puf_response_collector: a behavioural PUF answers
// each new challenge with its bitwise inverse, and directed vectors plus a few
// hand-written sequences check key, weight, challenge order and corner cases.
module tb_puf_response_collector;

    localparam int N_CHALL = 4;
    localparam int HW_W    = 6;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [7:0]           seed = 8'h00;
    logic                 puf_ready = 1'b0;
    logic [7:0]           puf_response = 8'h00;
    logic                 puf_en;
    logic [7:0]           puf_chall;
    logic                 busy;
    logic [8*N_CHALL-1:0] key;
    logic                 key_valid;
    logic [HW_W-1:0]      hw_total;
    logic                 timeout_err;

    puf_response_collector #(
        .N_CHALL (N_CHALL),
        .HW_W    (HW_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .puf_ready    (puf_ready),
        .puf_response (puf_response),
        .puf_en       (puf_en),
        .puf_chall    (puf_chall),
        .busy         (busy),
        .key          (key),
        .key_valid    (key_valid),
        .hw_total     (hw_total),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // PUF model state
    logic       puf_mute   = 1'b0;
    logic       pm_prev_en = 1'b0;
    logic [7:0] pm_chall   = 8'h00;
    int         pm_cnt     = 0;
    logic [7:0] chall_log [0:7];
    int         chall_n    = 0;

    typedef struct {
        logic [7:0]  seed;
        logic [31:0] chs;   // expected challenges, first in the MSBs
        logic [31:0] key;
        logic [5:0]  hw;
    } vec_t;

    vec_t vecs [0:3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural PUF: new challenge (en rise or chall change) -> ready on
    // the 3rd and 4th cycle afterwards, response = ~challenge.
    always @(negedge clk) begin
        if (!rst || puf_en !== 1'b1) begin
            puf_ready    = 1'b0;
            puf_response = 8'h00;
            pm_prev_en   = 1'b0;
            pm_cnt       = 0;
        end else begin
            if (!pm_prev_en || puf_chall != pm_chall) begin
                pm_chall = puf_chall;
                pm_cnt   = 1;
                if (chall_n < 8) chall_log[chall_n] = puf_chall;
                chall_n++;
            end else begin
                pm_cnt++;
            end
            pm_prev_en   = 1'b1;
            puf_ready    = !puf_mute && (pm_cnt == 3 || pm_cnt == 4);
            puf_response = puf_ready ? ~pm_chall : 8'h00;
        end
    end

    task automatic start_run(input logic [7:0] s);
        @(negedge clk);
        seed    = s;
        start   = 1'b1;
        chall_n = 0;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (key_valid === 1'b1 || timeout_err === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_done_wait"}, 64'd0, 64'd1);
    endtask

    task automatic check_run(input string name, input vec_t v);
        logic [31:0] chs;
        wait_done(name);
        chs = v.chs;
        chk({name, "_nchall"}, 64'(chall_n), 64'(N_CHALL));
        for (int r = 0; r < N_CHALL; r++) begin
            chk($sformatf("%s_chall%0d", name, r), 64'(chall_log[r]), 64'(chs[31-8*r -: 8]));
        end
        chk({name, "_key"},       64'(key),         64'(v.key));
        chk({name, "_hw"},        64'(hw_total),    64'(v.hw));
        chk({name, "_key_valid"}, 64'(key_valid),   64'd1);
        chk({name, "_busy"},      64'(busy),        64'd0);
        chk({name, "_puf_en"},    64'(puf_en),      64'd0);
        chk({name, "_tout"},      64'(timeout_err), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_puf_en"},    64'(puf_en),      64'd0);
        chk({name, "_puf_chall"}, 64'(puf_chall),   64'd0);
        chk({name, "_busy"},      64'(busy),        64'd0);
        chk({name, "_key"},       64'(key),         64'd0);
        chk({name, "_key_valid"}, 64'(key_valid),   64'd0);
        chk({name, "_hw"},        64'(hw_total),    64'd0);
        chk({name, "_tout"},      64'(timeout_err), 64'd0);
    endtask

    initial begin
        bit ok;
        bit saw_kv;

        vecs[0] = '{seed: 8'hD4, chs: 32'hD4A851A3, key: 32'h2B57AE5C, hw: 6'd18};
        vecs[1] = '{seed: 8'h00, chs: 32'h01020408, key: 32'hFEFDFBF7, hw: 6'd28};
        vecs[2] = '{seed: 8'hFF, chs: 32'hFFFEFCF8, key: 32'h00010307, hw: 6'd6};
        vecs[3] = '{seed: 8'h80, chs: 32'h80010204, key: 32'h7FFEFDFB, hw: 6'd28};

        // Reset held two cycles with start asserted
        rst   = 1'b0;
        start = 1'b1;
        seed  = 8'hD4;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Table of complete runs
        for (int v = 0; v < 4; v++) begin
            start_run(vecs[v].seed);
            check_run($sformatf("vec%0d", v), vecs[v]);
        end

        // start pulsed during round 2 is ignored
        start_run(8'hD4);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (chall_n >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ignore_wait", 64'd0, 64'd1);
        seed  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_run("ignore", vecs[0]);

        // start in DONE: key_valid drops next cycle and new seed runs
        @(negedge clk);
        seed    = 8'h00;
        start   = 1'b1;
        chall_n = 0;
        @(negedge clk);
        start   = 1'b0;
        #1;
        chk("restart_kv_drop", 64'(key_valid), 64'd0);
        chk("restart_busy",    64'(busy),      64'd1);
        check_run("restart", vecs[1]);

        // Handshake timeout: PUF never answers
        puf_mute = 1'b1;
        start_run(8'hD4);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (puf_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("tout_en_wait", 64'd0, 64'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) @(negedge clk);
        chk("tout_early", 64'(timeout_err), 64'd0);
        @(negedge clk);
        chk("tout_err",       64'(timeout_err), 64'd1);
        chk("tout_busy",      64'(busy),        64'd0);
        chk("tout_puf_en",    64'(puf_en),      64'd0);
        chk("tout_key",       64'(key),         64'd0);
        chk("tout_hw",        64'(hw_total),    64'd0);
        chk("tout_key_valid", 64'(key_valid),   64'd0);
        puf_mute = 1'b0;
        start_run(8'h80);
        chk("tout_cleared", 64'(timeout_err), 64'd0);
        check_run("after_tout", vecs[3]);

        // Reset during WAIT_LOW of round 3
        start_run(8'hD4);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (chall_n == 3 && puf_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("midrst_wait", 64'd0, 64'd1);
        @(negedge clk);
        #1;
        chk("midrst_pre_hw", 64'(hw_total), 64'd14);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        saw_kv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1 || busy === 1'b1) saw_kv = 1'b1;
        end
        chk("midrst_no_kv", 64'(saw_kv), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
